spi_xfer_ctrl: RTL and testbench

//  Wishbone master sequencer for the simple SPI core: runs one complete SPI transfer per request.
//  Per request: programs SPCR/SPER, asserts slave select, sends N bytes and returns N received bytes.

---
 rtl/spi_xfer_ctrl.sv | 179 +++++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_ctrl.sv
// rtl/spi_xfer_ctrl.sv - Wishbone master sequencing one complete SPI transfer per request on the simple SPI core.
// Optional poll timeout abort enabled by defining SPI_XFER_TIMEOUT_EN.
module spi_xfer_ctrl #(
    parameter int SS_WIDTH = 1
`ifdef SPI_XFER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 4096
`endif
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [7:0]          cfg_spcr,
    input  logic [7:0]          cfg_sper,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [3:0]          req_len,
    input  logic [SS_WIDTH-1:0] req_ss,
    input  logic                tx_valid,
    output logic                tx_ready,
    input  logic [7:0]          tx_data,
    output logic                rx_valid,
    output logic [7:0]          rx_data,
    output logic                done,
    output logic                err,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    output logic                wb_we_o,
    output logic [2:0]          wb_adr_o,
    output logic [7:0]          wb_dat_o,
    input  logic [7:0]          wb_dat_i,
    input  logic                wb_ack_i
);

    typedef enum logic [3:0] {
        S_IDLE, S_W_SPCR, S_W_SPER, S_W_SSON, S_TX_WAIT,
        S_TX_WR, S_POLL, S_RX_RD, S_W_SSOFF, S_DONE
    } state_t;

    state_t              r_state, w_next;
    logic                r_stb, r_we;
    logic [2:0]          r_adr;
    logic [7:0]          r_dat;
    logic [3:0]          r_cnt, r_len;
    logic [SS_WIDTH-1:0] r_ss;
    logic                r_rx_valid, r_tx_ready;
    logic [7:0]          r_rx_data;
    logic                w_ack_hit, w_acc, w_we, w_timeout;
    logic [2:0]          w_adr;
    logic [7:0]          w_dat;

    assign w_ack_hit = r_stb & wb_ack_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_acc  = 1'b0;
        w_we   = 1'b0;
        w_adr  = 3'd0;
        w_dat  = 8'h00;
        case (r_state)
            S_IDLE:    if (req_valid) w_next = S_W_SPCR;
            S_W_SPCR: begin
                w_acc = 1'b1; w_we = 1'b1; w_adr = 3'd0; w_dat = cfg_spcr | 8'h40;
                if (w_ack_hit) w_next = S_W_SPER;
            end
            S_W_SPER: begin
                w_acc = 1'b1; w_we = 1'b1; w_adr = 3'd3; w_dat = cfg_sper;
                if (w_ack_hit) w_next = S_W_SSON;
            end
            S_W_SSON: begin
                w_acc = 1'b1; w_we = 1'b1; w_adr = 3'd4; w_dat = 8'(r_ss);
                if (w_ack_hit) w_next = S_TX_WAIT;
            end
            S_TX_WAIT: if (tx_valid) w_next = S_TX_WR;
            S_TX_WR: begin
                w_acc = 1'b1; w_we = 1'b1; w_adr = 3'd2; w_dat = tx_data;
                if (w_ack_hit) w_next = S_POLL;
            end
            S_POLL: begin
                // SPSR bit0 is rfempty: a received byte is waiting once it reads 0
                w_acc = 1'b1; w_adr = 3'd1;
                if (w_ack_hit) begin
                    if (!wb_dat_i[0])   w_next = S_RX_RD;
                    else if (w_timeout) w_next = S_W_SSOFF;
                end
            end
            S_RX_RD: begin
                w_acc = 1'b1; w_adr = 3'd2;
                if (w_ack_hit) w_next = (r_cnt == r_len) ? S_W_SSOFF : S_TX_WAIT;
            end
            S_W_SSOFF: begin
                w_acc = 1'b1; w_we = 1'b1; w_adr = 3'd4;
                if (w_ack_hit) w_next = S_DONE;
            end
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Bus fields are captured when strobe rises, so a new access always waits one idle cycle after ack
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stb <= 1'b0;
            r_we  <= 1'b0;
            r_adr <= 3'd0;
            r_dat <= 8'h00;
        end else if (w_ack_hit) begin
            r_stb <= 1'b0;
        end else if (!r_stb && w_acc) begin
            r_stb <= 1'b1;
            r_we  <= w_we;
            r_adr <= w_adr;
            r_dat <= w_dat;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt      <= 4'd0;
            r_len      <= 4'd0;
            r_ss       <= '0;
            r_rx_valid <= 1'b0;
            r_tx_ready <= 1'b0;
            r_rx_data  <= 8'h00;
        end else begin
            r_rx_valid <= (r_state == S_RX_RD) && w_ack_hit;
            r_tx_ready <= (r_state == S_TX_WR) && w_ack_hit;
            if ((r_state == S_RX_RD) && w_ack_hit) r_rx_data <= wb_dat_i;
            if ((r_state == S_IDLE) && req_valid) begin
                r_len <= req_len;
                r_ss  <= req_ss;
                r_cnt <= 4'd0;
            end else if ((r_state == S_RX_RD) && w_ack_hit && (r_cnt != r_len)) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

`ifdef SPI_XFER_TIMEOUT_EN
    localparam int PW = $clog2(TIMEOUT_CYC + 1);
    logic [PW-1:0] r_poll_cnt;
    logic          r_to;

    assign w_timeout = (r_poll_cnt == PW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_poll_cnt <= '0;
            r_to       <= 1'b0;
        end else begin
            if ((w_next == S_POLL) && (r_state != S_POLL)) r_poll_cnt <= '0;
            else if ((r_state == S_POLL) && w_ack_hit)    r_poll_cnt <= r_poll_cnt + 1'b1;
            if (r_state == S_IDLE) r_to <= 1'b0;
            else if ((r_state == S_POLL) && (w_next == S_W_SSOFF)) r_to <= 1'b1;
        end
    end

    assign err = (r_state == S_DONE) && r_to;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    assign req_ready = (r_state == S_IDLE);
    assign done      = (r_state == S_DONE);
    assign tx_ready  = r_tx_ready;
    assign rx_valid  = r_rx_valid;
    assign rx_data   = r_rx_data;
    assign wb_cyc_o  = r_stb;
    assign wb_stb_o  = r_stb;
    assign wb_we_o   = r_we;
    assign wb_adr_o  = r_adr;
    assign wb_dat_o  = r_dat;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb/tb_spi_xfer_ctrl.sv - Table-driven bench for spi_xfer_ctrl with a loopback SPI core bus model.
module tb_spi_xfer_ctrl;
    localparam int SSW = 2;
    localparam int TO  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_i, req_valid, req_ready, tx_valid, tx_ready, rx_valid, done, err;
    logic [7:0]     cfg_spcr, cfg_sper, tx_data, rx_data, wb_dat_o, wb_dat_i;
    logic [3:0]     req_len;
    logic [SSW-1:0] req_ss;
    logic           wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
    logic [2:0]     wb_adr_o;

    spi_xfer_ctrl #(
        .SS_WIDTH(SSW)
`ifdef SPI_XFER_TIMEOUT_EN
        , .TIMEOUT_CYC(TO)
`endif
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .cfg_spcr(cfg_spcr), .cfg_sper(cfg_sper),
        .req_valid(req_valid), .req_ready(req_ready), .req_len(req_len), .req_ss(req_ss),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_data(rx_data), .done(done), .err(err),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
    );

    typedef struct {
        logic [7:0]     spcr, sper;
        logic [3:0]     len;
        logic [SSW-1:0] ss;
        logic [7:0]     base;
        int             delay, k, gap;
        bit             stuck;
        logic [7:0]     exp_spcr;
        int             exp_nacc;
        bit             exp_err;
    } vec_t;

    int n_applied = 0;
    int n_miss    = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // SPI core bus model: SPDR writes loop back after m_k further SPSR polls
    int          m_delay = 0, m_k = 0, m_pend = 0, m_wait = 0, m_unstable = 0;
    bit          m_stuck = 0;
    logic [7:0]  m_rxq[$];
    logic [11:0] m_log[$];
    logic [11:0] m_cap;

    initial begin
        logic [11:0] cur;
        wb_ack_i = 1'b0;
        wb_dat_i = 8'h00;
        forever begin
            @(negedge clk);
            if (wb_ack_i) begin
                wb_ack_i = 1'b0;
                m_wait   = 0;
            end else if (wb_stb_o) begin
                cur = {wb_we_o, wb_adr_o, wb_dat_o};
                if (m_wait == 0) m_cap = cur;
                else if (cur !== m_cap || !wb_cyc_o) m_unstable++;
                if (m_wait >= m_delay) begin
                    wb_ack_i = 1'b1;
                    if (wb_we_o) begin
                        m_log.push_back(cur);
                        if (wb_adr_o == 3'd2 && !m_stuck) begin
                            m_rxq.push_back(wb_dat_o);
                            m_pend = m_k;
                        end
                    end else begin
                        m_log.push_back({1'b0, wb_adr_o, 8'h00});
                        if (wb_adr_o == 3'd1) begin
                            if (m_pend > 0) begin
                                m_pend--;
                                wb_dat_i = 8'h01;
                            end else begin
                                wb_dat_i = (m_rxq.size() == 0) ? 8'h01 : 8'h00;
                            end
                        end else if (wb_adr_o == 3'd2) begin
                            wb_dat_i = (m_rxq.size() != 0) ? m_rxq.pop_front() : 8'h00;
                        end
                    end
                end else begin
                    m_wait++;
                end
            end else begin
                m_wait = 0;
            end
        end
    end

    logic [11:0] exp_log[$];
    logic [7:0]  got[$];

    task automatic run_xfer(input vec_t v, input bit abort);
        int  ti, n_txr, n_done, n_err, gap_cnt, gap_stb, post;
        bit  gap_done, fin;
        m_delay = v.delay; m_k = v.k; m_stuck = v.stuck; m_pend = 0; m_unstable = 0;
        m_rxq.delete(); m_log.delete(); got.delete();
        cfg_spcr = v.spcr; cfg_sper = v.sper; req_len = v.len; req_ss = v.ss;
        tx_data = v.base; tx_valid = 1'b0; req_valid = 1'b1;
        ti = 0; n_txr = 0; n_done = 0; n_err = 0; gap_cnt = 0; gap_stb = 0; post = 0;
        gap_done = (v.gap == 0); fin = 0;
        for (int c = 0; c < 3000 && post < 4; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (abort && wb_stb_o && !wb_we_o && wb_adr_o == 3'd1) begin
                rst_i = 1'b1; tx_valid = 1'b0;
                @(negedge clk);
                check("midrst_outputs", {wb_stb_o, wb_cyc_o, req_ready, done, rx_valid, tx_ready}, 6'b001000);
                rst_i = 1'b0;
                return;
            end
            if (tx_ready) begin
                n_txr++; ti++;
                tx_data = v.base + 8'(ti);
            end
            if (rx_valid) got.push_back(rx_data);
            if (done) begin n_done++; fin = 1; end
            if (err) n_err++;
            if (fin) post++;
            if (!gap_done && m_log.size() >= 3) begin
                if (gap_cnt >= 2 && wb_stb_o) gap_stb++;
                gap_cnt++;
                if (gap_cnt == v.gap + 2) gap_done = 1;
            end
            tx_valid = gap_done && (ti <= int'(v.len));
        end
        tx_valid = 1'b0;
        check("done_seen", fin, 1);
        if (abort) check("abort_not_reached", 1, 0);
        check("done_pulses", n_done, 1);
        check("err_pulses", n_err, v.exp_err);
        check("tx_ready_pulses", n_txr, int'(v.len) + 1);
        check("rx_valid_pulses", got.size(), v.stuck ? 0 : int'(v.len) + 1);
        for (int i = 0; i < got.size(); i++) check("rx_byte", got[i], v.base + 8'(i));
        check("wb_access_count", m_log.size(), v.exp_nacc);
        if (m_log.size() > 0) check("spcr_write", m_log[0], {1'b1, 3'd0, v.exp_spcr});
        check("wb_held_during_stall", m_unstable, 0);
        if (v.gap != 0) check("no_wb_in_tx_wait", gap_stb, 0);
        exp_log.delete();
        exp_log.push_back({1'b1, 3'd0, v.spcr | 8'h40});
        exp_log.push_back({1'b1, 3'd3, v.sper});
        exp_log.push_back({1'b1, 3'd4, 8'(v.ss)});
        for (int b = 0; b <= int'(v.len); b++) begin
            exp_log.push_back({1'b1, 3'd2, v.base + 8'(b)});
            if (v.stuck) begin
                for (int p = 0; p < TO; p++) exp_log.push_back({1'b0, 3'd1, 8'h00});
            end else begin
                for (int p = 0; p <= v.k; p++) exp_log.push_back({1'b0, 3'd1, 8'h00});
                exp_log.push_back({1'b0, 3'd2, 8'h00});
            end
        end
        exp_log.push_back({1'b1, 3'd4, 8'h00});
        for (int i = 0; i < exp_log.size() && i < m_log.size(); i++)
            check($sformatf("wb_access_%0d", i), m_log[i], exp_log[i]);
    endtask

    vec_t vt[5];
    int   n_vec;

    initial begin
        //       spcr   sper   len    ss     base   dly k  gap stuck exp_spcr nacc err
        vt[0] = '{8'h10, 8'h00, 4'd0,  2'b01, 8'hA5, 0,  2, 0,  0,    8'h50,   9,   0};
        vt[1] = '{8'h13, 8'h02, 4'd15, 2'b01, 8'h00, 0,  0, 0,  0,    8'h53,   52,  0};
        vt[2] = '{8'h10, 8'h00, 4'd0,  2'b01, 8'hA5, 3,  2, 10, 0,    8'h50,   9,   0};
        vt[3] = '{8'h52, 8'h01, 4'd2,  2'b10, 8'h3C, 1,  1, 0,  0,    8'h52,   16,  0};
        vt[4] = '{8'h10, 8'h00, 4'd0,  2'b01, 8'h77, 0,  0, 0,  1,    8'h50,   13,  1};
`ifdef SPI_XFER_TIMEOUT_EN
        n_vec = 5;
`else
        n_vec = 4;
`endif
        rst_i = 1'b1; req_valid = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        cfg_spcr = 8'h00; cfg_sper = 8'h00; req_len = 4'd0; req_ss = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {req_ready, wb_stb_o, wb_cyc_o, done, err, rx_valid, tx_ready}, 7'b1000000);
        rst_i = 1'b0;
        for (int i = 0; i < n_vec; i++) run_xfer(vt[i], 1'b0);
        run_xfer(vt[3], 1'b1);
        run_xfer(vt[0], 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end
endmodule
